rbus_pkt_obuf: RTL and testbench

- Store-and-forward packet buffer placed directly downstream of each output channel of the rbus N-to-M mux stage.
- It absorbs whole rbus packets into two per-class FIFOs and replays each packet contiguously to the next rbus consumer.
- It regenerates rdy/rdyE towards the mux from its own free space.
- It flags protocol and overflow errors on a sticky ff_err.

---
 rtl/rbus_pkt_obuf_if.sv | 11 +
 rtl/rbus_pkt_obuf.sv | 161 ++++++++++++++++
 tb/tb_rbus_pkt_obuf.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rbus_pkt_obuf_if.sv
// rbus word channel: strobe/sof/data forward, per-class rdy/rdyE back.
interface rbus_pkt_obuf_if;
  logic        stb;
  logic        sof;
  logic [71:0] data;
  logic [1:0]  rdy;
  logic [1:0]  rdyE;

  modport master (output stb, sof, data, input rdy, rdyE);
  modport slave  (input stb, sof, data, output rdy, rdyE);
endinterface

// File: rtl/rbus_pkt_obuf.sv
// Store-and-forward rbus packet buffer: two class FIFOs, whole-packet replay,
// rdy/rdyE regenerated from local free space, sticky error flag.
module rbus_pkt_obuf #(
  parameter int DEPTH   = 64,
  parameter int MAX_LEN = 16
) (
  input  logic           clk,
  input  logic           rst,
  rbus_pkt_obuf_if.slave  i_bus,
  rbus_pkt_obuf_if.master o_bus,
  output logic           ff_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LMAX    = LW'(MAX_LEN);
  localparam logic [AW:0]   RDY_LIM = (AW+1)'(DEPTH - MAX_LEN);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  // write-side packet tracking
  logic          r_open, r_cls, r_vld, r_keep;
  logic [LW-1:0] r_len;
  // read-side FSM and registered outputs
  state_t        r_st;
  logic          r_sel, r_ostb, r_osof;
  logic [71:0]   r_odata;

  logic [1:0]    w_full, w_empty, w_wr, w_rd, w_close, w_dec, w_avail, w_rdy, w_rdyE;
  logic [72:0]   w_head [2];
  logic [CW-1:0] w_pcnt [2];
  logic          w_wcls, w_err, w_unused;

  assign w_unused = ^o_bus.rdyE;
  assign w_wcls   = i_bus.sof ? i_bus.data[71] : r_cls;

  // Decide per word whether it is stored, dropped or flagged; close packets
  // whose sof made it into a FIFO.
  always_comb begin
    w_wr    = '0;
    w_close = '0;
    w_err   = 1'b0;
    if (r_open && r_vld && (!i_bus.stb || i_bus.sof)) w_close[r_cls] = 1'b1;
    if (i_bus.stb) begin
      if (i_bus.sof) begin
        if (w_full[w_wcls]) w_err = 1'b1;
        else                w_wr[w_wcls] = 1'b1;
      end else if (!r_open) begin
        w_err = 1'b1;
      end else if (r_keep) begin
        if (r_len >= LMAX || w_full[r_cls]) w_err = 1'b1;
        else                                w_wr[r_cls] = 1'b1;
      end
    end
  end

  // Packet framing state and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_open <= 1'b0; r_cls <= 1'b0; r_vld <= 1'b0; r_keep <= 1'b0;
      r_len  <= '0;   ff_err <= 1'b0;
    end else begin
      if (w_err) ff_err <= 1'b1;
      if (i_bus.stb && i_bus.sof) begin
        r_open <= 1'b1;
        r_cls  <= i_bus.data[71];
        r_vld  <= w_wr[w_wcls];
        r_keep <= w_wr[w_wcls];
        r_len  <= LW'(1);
      end else if (i_bus.stb && r_open) begin
        // A full FIFO kills the rest of the packet; over-length words just drop.
        if (w_wr[r_cls])       r_len  <= r_len + 1'b1;
        else if (r_len < LMAX) r_keep <= 1'b0;
      end else if (!i_bus.stb) begin
        r_open <= 1'b0; r_vld <= 1'b0; r_keep <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_cls
    logic [72:0]   r_mem [DEPTH];
    logic [AW:0]   r_wp, r_rp;
    logic [CW-1:0] r_pcnt;
    logic          r_rdy, r_rdyE;
    logic [AW:0]   w_fill, w_nfill;

    assign w_fill     = r_wp - r_rp;
    assign w_nfill    = w_fill + (AW+1)'(w_wr[k]) - (AW+1)'(w_rd[k]);
    assign w_full[k]  = w_fill[AW];
    assign w_empty[k] = (w_fill == '0);
    assign w_head[k]  = r_mem[r_rp[AW-1:0]];
    assign w_pcnt[k]  = r_pcnt;
    assign w_rdy[k]   = r_rdy;
    assign w_rdyE[k]  = r_rdyE;
    // A packet just closing counts as available so replay can start at once.
    assign w_avail[k] = (r_pcnt != '0 || w_close[k]) && o_bus.rdy[k];

    // FIFO storage; sof kept as bit 72.
    always_ff @(posedge clk) begin
      if (w_wr[k]) r_mem[r_wp[AW-1:0]] <= {i_bus.sof, i_bus.data};
    end

    // Pointers, completed-packet count and regenerated ready flags.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_wp <= '0; r_rp <= '0; r_pcnt <= '0; r_rdy <= 1'b0; r_rdyE <= 1'b0;
      end else begin
        if (w_wr[k]) r_wp <= r_wp + 1'b1;
        if (w_rd[k]) r_rp <= r_rp + 1'b1;
        r_pcnt <= r_pcnt + CW'(w_close[k]) - CW'(w_dec[k]);
        r_rdy  <= (w_nfill <= RDY_LIM);
        r_rdyE <= w_empty[k] && (r_pcnt == '0) && !w_wr[k] && !w_close[k] &&
                  !(r_open && r_cls == 1'(k)) &&
                  !(r_st == S_SEND && r_sel == 1'(k));
      end
    end
  end

  // Pop control: class 1 wins in IDLE; SEND pops until the next sof or empty.
  always_comb begin
    w_rd  = '0;
    w_dec = '0;
    if (r_st == S_IDLE) begin
      if (w_avail[1])      w_rd[1] = 1'b1;
      else if (w_avail[0]) w_rd[0] = 1'b1;
    end else if (!w_empty[r_sel] && !w_head[r_sel][72]) begin
      w_rd[r_sel] = 1'b1;
    end else begin
      w_dec[r_sel] = 1'b1;
    end
  end

  // Read FSM with registered output word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_st <= S_IDLE; r_sel <= 1'b0; r_ostb <= 1'b0; r_osof <= 1'b0; r_odata <= '0;
    end else if (r_st == S_IDLE) begin
      if (|w_rd) begin
        r_st    <= S_SEND;
        r_sel   <= w_rd[1];
        r_ostb  <= 1'b1;
        r_osof  <= w_head[w_rd[1]][72];
        r_odata <= w_head[w_rd[1]][71:0];
      end
    end else if (|w_rd) begin
      r_ostb  <= 1'b1;
      r_osof  <= w_head[r_sel][72];
      r_odata <= w_head[r_sel][71:0];
    end else begin
      r_st   <= S_IDLE;
      r_ostb <= 1'b0;
      r_osof <= 1'b0;
    end
  end

  assign o_bus.stb  = r_ostb;
  assign o_bus.sof  = r_osof;
  assign o_bus.data = r_odata;
  assign i_bus.rdy  = w_rdy;
  assign i_bus.rdyE = w_rdyE;
endmodule

// File: tb/tb_rbus_pkt_obuf.sv
// Directed bench for rbus_pkt_obuf: framing, latency, priority, fill, errors.
module tb_rbus_pkt_obuf;
  logic clk, rst, ff_err;
  int   cyc, n_chk, n_err, t_last;

  rbus_pkt_obuf_if u_in ();
  rbus_pkt_obuf_if u_out ();

  rbus_pkt_obuf #(.DEPTH(64), .MAX_LEN(16)) dut (
    .clk(clk), .rst(rst), .i_bus(u_in), .o_bus(u_out), .ff_err(ff_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // output capture
  logic [71:0] q_d [$];
  logic        q_s [$];
  int          q_c [$];
  always @(negedge clk) begin
    if (rst && u_out.stb) begin
      q_d.push_back(u_out.data); q_s.push_back(u_out.sof); q_c.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [71:0] mkw(input logic cls, input int v);
    return {cls, 71'(v)};
  endfunction

  task automatic q_clr();
    q_d.delete(); q_s.delete(); q_c.delete();
  endtask

  task automatic send_pkt(input logic cls, input int len, input int base);
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      u_in.stb = 1'b1; u_in.sof = (i == 0); u_in.data = mkw(cls, base + i);
      t_last = cyc;
    end
    @(posedge clk); #1;
    u_in.stb = 1'b0; u_in.sof = 1'b0; u_in.data = '0;
  endtask

  task automatic wait_q(input int n, input int budget);
    int b;
    b = 0;
    while (q_d.size() < n && b < budget) begin @(negedge clk); b++; end
    if (q_d.size() < n) chk("timeout", 128'(q_d.size()), 128'(n));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
  endtask

  initial begin
    cyc = 0; n_chk = 0; n_err = 0; t_last = 0;
    rst = 1'b0;
    u_in.stb = 1'b0; u_in.sof = 1'b0; u_in.data = '0;
    u_out.rdy = 2'b00; u_out.rdyE = 2'b00;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy",  128'(u_in.rdy),   128'(0));
    chk("rst_rdyE", 128'(u_in.rdyE),  128'(0));
    chk("rst_ostb", 128'(u_out.stb),  128'(0));
    chk("rst_osof", 128'(u_out.sof),  128'(0));
    chk("rst_odat", 128'(u_out.data), 128'(0));
    chk("rst_err",  128'(ff_err),     128'(0));
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post_rdy",  128'(u_in.rdy),  128'(2'b11));
    chk("post_rdyE", 128'(u_in.rdyE), 128'(2'b11));
    chk("post_err",  128'(ff_err),    128'(0));

    // single class-0 packet, latency and contiguity
    u_out.rdy = 2'b11; q_clr();
    send_pkt(1'b0, 4, 1);
    wait_q(4, 30);
    if (q_d.size() >= 4) begin
      chk("lat", 128'(q_c[0]), 128'(t_last + 2));
      for (int i = 0; i < 4; i++) begin
        chk("p1_dat", 128'(q_d[i]), 128'(mkw(1'b0, 1 + i)));
        chk("p1_sof", 128'(q_s[i]), 128'(i == 0));
        chk("p1_cyc", 128'(q_c[i]), 128'(q_c[0] + i));
      end
    end
    idle(6);
    chk("p1_rdyE", 128'(u_in.rdyE), 128'(2'b11));
    chk("p1_err",  128'(ff_err),    128'(0));

    // priority: class 1 leaves first once both are buffered
    u_out.rdy = 2'b00; q_clr();
    send_pkt(1'b0, 3, 'h10);
    send_pkt(1'b1, 2, 'h20);
    idle(3);
    chk("pr_hold", 128'(q_d.size()), 128'(0));
    chk("pr_rdyE", 128'(u_in.rdyE),  128'(2'b00));
    @(posedge clk); #1; u_out.rdy = 2'b11;
    wait_q(5, 30);
    if (q_d.size() >= 5) begin
      chk("pr_w0", 128'(q_d[0]), 128'(mkw(1'b1, 'h20)));
      chk("pr_s0", 128'(q_s[0]), 128'(1));
      chk("pr_w1", 128'(q_d[1]), 128'(mkw(1'b1, 'h21)));
      chk("pr_w2", 128'(q_d[2]), 128'(mkw(1'b0, 'h10)));
      chk("pr_s2", 128'(q_s[2]), 128'(1));
      chk("pr_w4", 128'(q_d[4]), 128'(mkw(1'b0, 'h12)));
      chk("pr_gap", 128'(q_c[2] - q_c[1] >= 2), 128'(1));
    end
    idle(4);

    // backpressure fill of class 0
    u_out.rdy = 2'b00; q_clr();
    for (int p = 0; p < 3; p++) send_pkt(1'b0, 16, (p + 1) * 'h100);
    idle(2);
    chk("bp_rdy3", 128'(u_in.rdy), 128'(2'b11));
    send_pkt(1'b0, 16, 'h400);
    idle(2);
    chk("bp_rdy4", 128'(u_in.rdy), 128'(2'b10));
    chk("bp_err",  128'(ff_err),   128'(0));

    // overflow: 5th packet into full class 0
    send_pkt(1'b0, 16, 'h500);
    idle(1);
    chk("ov_err", 128'(ff_err), 128'(1));
    idle(4);
    chk("ov_err_hold", 128'(ff_err), 128'(1));
    u_out.rdy = 2'b11;
    wait_q(64, 300);
    idle(10);
    chk("ov_cnt", 128'(q_d.size()), 128'(64));
    if (q_d.size() >= 64) begin
      for (int i = 0; i < 64; i++) begin
        chk("ov_dat", 128'(q_d[i]), 128'(mkw(1'b0, ((i / 16) + 1) * 'h100 + (i % 16))));
        chk("ov_sof", 128'(q_s[i]), 128'((i % 16) == 0));
      end
    end
    chk("ov_rdy",  128'(u_in.rdy),  128'(2'b11));
    chk("ov_rdyE", 128'(u_in.rdyE), 128'(2'b11));

    // protocol error: stray non-sof word
    do_reset(); q_clr();
    idle(1);
    chk("pe_clr", 128'(ff_err), 128'(0));
    @(posedge clk); #1;
    u_in.stb = 1'b1; u_in.sof = 1'b0; u_in.data = mkw(1'b1, 'h77);
    @(posedge clk); #1;
    u_in.stb = 1'b0; u_in.data = '0;
    idle(4);
    chk("pe_err",  128'(ff_err),     128'(1));
    chk("pe_none", 128'(q_d.size()), 128'(0));
    chk("pe_rdyE", 128'(u_in.rdyE),  128'(2'b11));
    send_pkt(1'b1, 2, 'h30);
    wait_q(2, 20);
    if (q_d.size() >= 2) begin
      chk("pe_w0", 128'(q_d[0]), 128'(mkw(1'b1, 'h30)));
      chk("pe_w1", 128'(q_d[1]), 128'(mkw(1'b1, 'h31)));
    end

    // over-length packet is truncated to MAX_LEN
    do_reset(); q_clr();
    send_pkt(1'b1, 18, 'h600);
    wait_q(16, 60);
    idle(6);
    chk("ol_cnt", 128'(q_d.size()), 128'(16));
    chk("ol_err", 128'(ff_err),     128'(1));
    if (q_d.size() >= 16) chk("ol_last", 128'(q_d[15]), 128'(mkw(1'b1, 'h60F)));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
